stage4_resolve: RTL and testbench

Stage 4 of the 7-stage pipeline. It consumes stage 3's ALU result and compare flags, and resolves branches and jumps into a registered one-cycle redirect. It issues data-memory requests for loads and stores, stalling upstream until the memory acknowledges, and registers the writeback result for stage 5.

---
 rtl/stage4_resolve_if.sv | 23 ++
 rtl/stage4_resolve.sv | 161 ++++++++++++++++
 tb/tb_stage4_resolve.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage4_resolve_if.sv
// Data-memory request/response bus between stage 4 and the data memory.
// master: stage side drives req/we/size/addr/wdata; slave: memory drives ack/rdata.
interface stage4_resolve_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/stage4_resolve.sv
// Stage 4: branch/jump resolution, data-memory access with stall, writeback register.
// Ports: stage-3 inputs (in_*, compare, eval, rs2_val, imm), stall/redirect, mem bus, stage-5 outputs.
module stage4_resolve #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_op,
    input  logic            in_jalr,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic [1:0]      in_cond,
    input  logic [3:0]      compare,
    input  logic [XLEN-1:0] eval,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    stage4_resolve_if.master mem,
    output logic            out_valid,
    output logic            out_we,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            mem_we_q, mem_we_d;
    logic [1:0]      mem_size_q, mem_size_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic            out_valid_q, out_valid_d;
    logic            out_we_q, out_we_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_result_q, out_result_d;

    logic            accept;
    logic [XLEN-1:0] pc_imm;

    // The slot right after a redirect holds a wrong-path instruction.
    assign accept = in_valid && (state_q == RUN) && !redirect_valid_q;
    assign pc_imm = in_pc + imm;

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        mem_we_d         = mem_we_q;
        mem_size_d       = mem_size_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        pend_rd_d        = pend_rd_q;
        out_valid_d      = 1'b0;
        out_we_d         = 1'b0;
        out_rd_d         = out_rd_q;
        out_result_d     = out_result_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    unique case (1'b1)
                        in_op[2]: begin
                            state_d     = MEM_WAIT;
                            mem_we_d    = in_store;
                            mem_size_d  = in_size;
                            mem_addr_d  = eval;
                            mem_wdata_d = rs2_val;
                            pend_rd_d   = in_rd;
                        end
                        in_op[1]: begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = in_jalr ?
                                {eval[XLEN-1:1], 1'b0} : pc_imm;
                            out_valid_d  = 1'b1;
                            out_we_d     = (in_rd != 5'd0);
                            out_rd_d     = in_rd;
                            out_result_d = in_pc + XLEN'(4);
                        end
                        in_op[0]: begin
                            redirect_valid_d = compare[in_cond];
                            if (compare[in_cond]) begin
                                redirect_pc_d = pc_imm;
                            end
                            out_valid_d  = 1'b1;
                            out_rd_d     = in_rd;
                            out_result_d = '0;
                        end
                        default: begin
                            out_valid_d  = 1'b1;
                            out_we_d     = (in_rd != 5'd0);
                            out_rd_d     = in_rd;
                            out_result_d = eval;
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                if (mem.mem_ack) begin
                    state_d      = RUN;
                    out_valid_d  = 1'b1;
                    out_we_d     = !mem_we_q && (pend_rd_q != 5'd0);
                    out_rd_d     = pend_rd_q;
                    out_result_d = mem_we_q ? '0 : mem.mem_rdata;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mem_we_q         <= 1'b0;
            mem_size_q       <= 2'd0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            pend_rd_q        <= 5'd0;
            out_valid_q      <= 1'b0;
            out_we_q         <= 1'b0;
            out_rd_q         <= 5'd0;
            out_result_q     <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mem_we_q         <= mem_we_d;
            mem_size_q       <= mem_size_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            pend_rd_q        <= pend_rd_d;
            out_valid_q      <= out_valid_d;
            out_we_q         <= out_we_d;
            out_rd_q         <= out_rd_d;
            out_result_q     <= out_result_d;
        end
    end

    // Request and stall both come straight from the state register.
    assign stall          = (state_q == MEM_WAIT);
    assign mem.mem_req    = (state_q == MEM_WAIT);
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_size   = mem_size_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign out_valid      = out_valid_q;
    assign out_we         = out_we_q;
    assign out_rd         = out_rd_q;
    assign out_result     = out_result_q;

endmodule

// File: tb/tb_stage4_resolve.sv
// Self-checking bench for stage4_resolve: directed cases then random ops.
// Expected values come from a transaction-level model of the resolve rules.
module tb_stage4_resolve;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [2:0]  in_op;
    logic        in_jalr;
    logic        in_store;
    logic [1:0]  in_size;
    logic [1:0]  in_cond;
    logic [3:0]  compare;
    logic [31:0] eval;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_result;

    int n_checks = 0;
    int n_fail   = 0;

    stage4_resolve_if #(.XLEN(32)) mif ();

    stage4_resolve #(.XLEN(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_rd          (in_rd),
        .in_op          (in_op),
        .in_jalr        (in_jalr),
        .in_store       (in_store),
        .in_size        (in_size),
        .in_cond        (in_cond),
        .compare        (compare),
        .eval           (eval),
        .rs2_val        (rs2_val),
        .imm            (imm),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem            (mif.master),
        .out_valid      (out_valid),
        .out_we         (out_we),
        .out_rd         (out_rd),
        .out_result     (out_result)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          we;
        logic [31:0] res;
        bit          has_res;
    } exp_t;

    // kind: 0 ALU, 1 branch, 2 jump
    function automatic exp_t predict(int kind, bit jalr, int cond,
                                     logic [3:0] cmp, logic [31:0] pc,
                                     logic [4:0] rd, logic [31:0] ev,
                                     logic [31:0] im);
        exp_t e;
        e.redir = 0; e.rpc = 0; e.we = 0; e.res = 0; e.has_res = 0;
        if (kind == 2) begin
            e.redir   = 1;
            e.rpc     = jalr ? (ev & 32'hFFFF_FFFE) : pc + im;
            e.we      = (rd != 0);
            e.res     = pc + 32'd4;
            e.has_res = 1;
        end else if (kind == 1) begin
            e.redir = cmp[cond];
            e.rpc   = pc + im;
        end else begin
            e.we      = (rd != 0);
            e.res     = ev;
            e.has_res = 1;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic [2:0] op, logic [31:0] pc, logic [4:0] rd,
                         bit jalr, bit st, logic [1:0] sz,
                         logic [1:0] cond, logic [3:0] cmp,
                         logic [31:0] ev, logic [31:0] r2,
                         logic [31:0] im);
        in_valid = 1'b1;
        in_op = op; in_pc = pc; in_rd = rd; in_jalr = jalr;
        in_store = st; in_size = sz; in_cond = cond; compare = cmp;
        eval = ev; rs2_val = r2; imm = im;
    endtask

    task automatic drive_random(int kind);
        logic [2:0] op;
        case (kind)
            1: op = 3'b001;
            2: op = 3'b010;
            3: op = 3'b100;
            default: op = 3'b000;
        endcase
        drive(op, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom_range(0, 2)), 2'($urandom), 4'($urandom),
              $urandom, $urandom, $urandom);
    endtask

    // Non-memory op; a redirect is followed by a wrong-path slot.
    task automatic run_op(int kind, bit jalr, logic [1:0] cond,
                          logic [3:0] cmp, logic [31:0] pc,
                          logic [4:0] rd, logic [31:0] ev,
                          logic [31:0] im);
        exp_t e;
        logic [2:0] op;
        op = (kind == 2) ? 3'b010 : (kind == 1) ? 3'b001 : 3'b000;
        e = predict(kind, jalr, int'(cond), cmp, pc, rd, ev, im);
        drive(op, pc, rd, jalr, 1'b0, 2'd0, cond, cmp, ev,
              $urandom, im);
        mif.mem_ack = 1'($urandom);
        tick();
        mif.mem_ack = 1'b0;
        in_valid = 1'b0;
        chk("op_out_valid", out_valid, 1);
        chk("op_out_we", out_we, e.we);
        if (kind != 1) chk("op_out_rd", out_rd, rd);
        if (e.has_res) chk("op_out_result", out_result, e.res);
        chk("op_redirect_valid", redirect_valid, e.redir);
        if (e.redir) chk("op_redirect_pc", redirect_pc, e.rpc);
        chk("op_stall", stall, 0);
        chk("op_mem_req", mif.mem_req, 0);
        if (e.redir) begin
            drive_random($urandom_range(0, 3));
            tick();
            in_valid = 1'b0;
            chk("drop_out_valid", out_valid, 0);
            chk("drop_redirect", redirect_valid, 0);
            chk("drop_mem_req", mif.mem_req, 0);
        end
    endtask

    // Memory op acked after lat request cycles; an ALU op waits behind it.
    task automatic run_mem(bit st, logic [1:0] sz, logic [31:0] addr,
                           logic [4:0] rd, logic [31:0] wd,
                           logic [31:0] rdata, int lat,
                           logic [31:0] next_ev);
        drive(3'b100, $urandom, rd, 1'b0, st, sz, 2'd0, 4'd0, addr,
              wd, $urandom);
        tick();
        drive(3'b000, $urandom, 5'd3, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,
              next_ev, 32'd0, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            chk("mem_req", mif.mem_req, 1);
            chk("mem_stall", stall, 1);
            chk("mem_addr", mif.mem_addr, addr);
            chk("mem_we", mif.mem_we, st);
            chk("mem_size", mif.mem_size, sz);
            if (st) chk("mem_wdata", mif.mem_wdata, wd);
            chk("mem_wait_out_valid", out_valid, 0);
            mif.mem_ack   = (k == lat);
            mif.mem_rdata = rdata;
            tick();
        end
        mif.mem_ack = 1'b0;
        chk("mem_done_valid", out_valid, 1);
        chk("mem_done_we", out_we, !st && (rd != 0));
        chk("mem_done_rd", out_rd, rd);
        chk("mem_done_result", out_result, st ? 32'd0 : rdata);
        chk("mem_done_stall", stall, 0);
        chk("mem_done_req", mif.mem_req, 0);
        tick();
        in_valid = 1'b0;
        chk("next_out_valid", out_valid, 1);
        chk("next_out_result", out_result, next_ev);
        chk("next_out_rd", out_rd, 3);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_pc = 0; in_rd = 0; in_op = 0; in_jalr = 0; in_store = 0;
        in_size = 0; in_cond = 0; compare = 0; eval = 0;
        rs2_val = 0; imm = 0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        run_op(0, 0, 2'd0, 4'd0, 32'h0, 5'd5, 32'h10, 32'h0);
        run_op(0, 0, 2'd0, 4'd0, 32'h0, 5'd0, 32'h22, 32'h0);
        run_op(1, 0, 2'd2, 4'b0110, 32'h100, 5'd0, 32'h0,
               32'hFFFF_FFF0);
        run_op(1, 0, 2'd2, 4'b1010, 32'h100, 5'd0, 32'h0,
               32'hFFFF_FFF0);
        run_op(2, 1, 2'd0, 4'd0, 32'h40, 5'd1, 32'h2003, 32'h0);
        run_mem(0, 2'd2, 32'h800, 5'd7, 32'h0, 32'hDEAD_BEEF, 3,
                32'h1234);
        run_mem(1, 2'd2, 32'h900, 5'd9, 32'hCAFE_F00D, 32'h5555, 1,
                32'h4321);

        // Reset in the middle of a memory wait
        drive(3'b100, 32'h0, 5'd4, 1'b0, 1'b0, 2'd2, 2'd0, 4'd0,
              32'hA00, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_req", mif.mem_req, 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_req", mif.mem_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_addr", mif.mem_addr, 0);
        @(negedge clock);
        reset_n = 1'b1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'h7777_7777;
        tick();
        mif.mem_ack = 1'b0;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_req", mif.mem_req, 0);
        tick();
        chk("post_rst_out_valid2", out_valid, 0);

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [4:0] rd;
            kind = $urandom_range(0, 3);
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            if (kind == 3)
                run_mem(1'($urandom), 2'($urandom_range(0, 2)),
                        $urandom, rd, $urandom, $urandom,
                        $urandom_range(1, 4), $urandom);
            else
                run_op(kind, 1'($urandom), 2'($urandom), 4'($urandom),
                       $urandom, rd, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
